snake_step_ctrl: RTL and testbench
==================================

# snake_step_ctrl

Game sequencer for the snake design. It decodes UART key bytes (dataRX/WR_RX) into direction and start/pause/restart commands, and runs the run/pause/dead state machine. A fixed-rate prescaler generates the game step, and the block advances the head position on the cell grid with wrap-around. It sits between rxuart and the snake body/render logic, and replaces direct byte handling inside snake.

## Interface
- TICK_DIV, 2_500_000, clk cycles per game step (10 steps/s at 25 MHz); must be ≥2
- GRID_W, 40, grid columns (640/16)
- GRID_H, 30, grid rows (480/16)
- START_X, 20, head column after reset/restart
- START_Y, 15, head row after reset/restart

Ports:
- clk  in  1  system clock (25 MHz)
- rst  in  1  reset; one clock, reset is synchronous and active-high
- dataRX  in  8  received UART byte
- WR_RX  in  1  dataRX valid, one-cycle strobe
- collision  in  1  body lookup result for the new head, valid the cycle after step
- head_x  out  6  head column, 0..GRID_W-1
- head_y  out  5  head row, 0..GRID_H-1
- dir  out  2  committed direction: 0 up, 1 right, 2 down, 3 left
- step  out  1  one-cycle pulse; head_x/head_y carry the new value while high
- clear  out  1  one-cycle pulse on restart; body logic flushes
- state  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DEAD

## Operation
- Reset values:
  - state=IDLE, head=(START_X,START_Y), dir=1, pending_dir=1
  - step=0, clear=0, tick counter=0
- Keys are decoded only when WR_RX=1. Lowercase only; all other bytes are ignored.
  - 'w' 0x77 = up, 'd' 0x64 = right, 's' 0x73 = down, 'a' 0x61 = left
  - ' ' 0x20 = start/pause, 'r' 0x72 = restart
- Direction keys:
  - Accepted in IDLE, RUN and PAUSE; ignored in DEAD.
  - A key opposite to the committed dir is ignored (dir XOR key == 2).
  - Legal keys overwrite pending_dir, so the last legal key before a step wins.
- FSM:
  - IDLE --' '--> RUN
  - RUN --' '--> PAUSE
  - PAUSE --' '--> RUN
  - RUN --collision=1 in check cycle--> DEAD
  - Any state --'r'--> IDLE with the reset values above, plus clear=1 for one cycle.
  - DEAD exits only on 'r'.
- Tick counter:
  - Counts 0..TICK_DIV-1 only in RUN; holds its value in PAUSE.
  - Is zeroed in IDLE and DEAD.
- Step:
  - On the edge after the counter reaches TICK_DIV-1: the counter wraps to 0, dir←pending_dir, the head moves one cell in the new dir, and step=1.
- Wrap-around:
  - x = GRID_W-1 moving right → 0; x = 0 moving left → GRID_W-1.
  - Same rule on y with GRID_H.
- Check cycle:
  - Is the cycle after step. collision is sampled only there; at any other time it is ignored.

## Timing
- WR_RX edge → state/pending_dir/clear update: 1 clk (registered).
- Step period in uninterrupted RUN: exactly TICK_DIV clk.
- First step after IDLE→RUN occurs TICK_DIV clk after the space byte is accepted.
- Simultaneous events:
  - ' ' together with counter terminal: pause wins, no step, and the counter holds TICK_DIV-1. The step fires 1 clk after resume.
  - 'r' together with the check cycle: restart wins and collision is ignored.
  - Direction key in the same cycle as the step edge: the key is written to pending_dir and the legality check uses the dir value before the step.
- rst asserted mid-step or in the check cycle: all outputs take reset values on the next edge, and no DEAD transition occurs.

## Structure
- Shared package snake_pkg holds:
  - dir encodings (DIR_UP/RIGHT/DOWN/LEFT)
  - state encodings
  - ASCII key constants
  - GRID_W/GRID_H defaults
  - These are reused by snake body and render.
- One sub-module: snake_tick_gen.
  - Ports: clk, rst, clear, en.
  - Parameter TICK_DIV.
  - Output: terminal pulse.
  - Counter width $clog2(TICK_DIV).
- FSM, key decode and head arithmetic stay in snake_step_ctrl.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then ' ': state 0→1, first step pulse 4 clk later with head (21,15), then steps every 4 clk.
- Heading right, send 'a' then 'w' within one period: 'a' ignored, next step dir=0, head (x,14).
- Head at (39,15) moving right: next step gives (0,15). Head at (x,0) moving up gives (x,29).
- ' ' in the same cycle as counter terminal: no step, state=2. A second ' ' yields a step 1 clk later.
- collision=1 in the check cycle → state=3 and no further steps. 'r' → state=0, clear pulse, head (20,15), dir=1.
- collision=1 on a non-check cycle: ignored, state stays 1. 'r' coincident with the check-cycle collision → IDLE, not DEAD.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake design: direction and game-state
// encodings, UART key codes and default grid dimensions. Reused by the
// step controller, the body logic and the renderer.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  // Lowercase ASCII key codes; anything else is ignored
  localparam logic [7:0] KEY_UP      = 8'h77;  // 'w'
  localparam logic [7:0] KEY_RIGHT   = 8'h64;  // 'd'
  localparam logic [7:0] KEY_DOWN    = 8'h73;  // 's'
  localparam logic [7:0] KEY_LEFT    = 8'h61;  // 'a'
  localparam logic [7:0] KEY_SPACE   = 8'h20;  // start / pause
  localparam logic [7:0] KEY_RESTART = 8'h72;  // 'r'

  // 640x480 screen divided into 16x16 cells
  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;

  // Opposite directions differ exactly in bit 1 with the encoding above
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return (a ^ b) == 2'd2;
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Game-step prescaler: counts 0..TICK_DIV-1 while enabled, holds while
// disabled, and flags the terminal count so the caller can step on the
// following edge. clear zeroes the count and dominates en.
module snake_tick_gen #(
  parameter int TICK_DIV = 2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic terminal
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_count;

  assign terminal = en && (r_count == LAST);

  // Step counter: wraps at the terminal count, frozen when not enabled
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= terminal ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/snake_step_ctrl.sv
// Snake game sequencer: decodes UART key bytes into direction and
// start/pause/restart commands, runs the IDLE/RUN/PAUSE/DEAD machine and
// advances the head one cell per game step with wrap-around on the grid.
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 2_500_000,
  parameter int GRID_W   = GRID_W_DEF,
  parameter int GRID_H   = GRID_H_DEF,
  parameter int START_X  = 20,
  parameter int START_Y  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dataRX,
  input  logic       WR_RX,
  input  logic       collision,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [1:0] dir,
  output logic       step,
  output logic       clear,
  output logic [1:0] state
);

  localparam logic [5:0] X_START = 6'(START_X);
  localparam logic [4:0] Y_START = 5'(START_Y);
  localparam logic [5:0] X_LAST  = 6'(GRID_W - 1);
  localparam logic [4:0] Y_LAST  = 5'(GRID_H - 1);

  state_t     r_state;
  state_t     w_state_next;
  dir_t       r_dir;
  dir_t       r_pending_dir;
  logic [5:0] r_head_x;
  logic [4:0] r_head_y;
  logic       r_step;
  logic       r_check;
  logic       r_clear;

  dir_t       w_key_dir;
  logic       w_key_is_dir;
  logic       w_key_space;
  logic       w_restart;
  logic       w_dir_accept;
  logic       w_dead_hit;
  logic       w_tick_en;
  logic       w_tick_clr;
  logic       w_tick;
  logic [5:0] w_head_x_next;
  logic [4:0] w_head_y_next;

  // Key decode: only valid bytes with WR_RX high count as keys
  always_comb begin
    w_key_dir    = DIR_UP;
    w_key_is_dir = 1'b0;
    case (dataRX)
      KEY_UP:    begin w_key_dir = DIR_UP;    w_key_is_dir = WR_RX; end
      KEY_RIGHT: begin w_key_dir = DIR_RIGHT; w_key_is_dir = WR_RX; end
      KEY_DOWN:  begin w_key_dir = DIR_DOWN;  w_key_is_dir = WR_RX; end
      KEY_LEFT:  begin w_key_dir = DIR_LEFT;  w_key_is_dir = WR_RX; end
      default:   begin w_key_dir = DIR_UP;    w_key_is_dir = 1'b0;  end
    endcase
  end

  assign w_key_space  = WR_RX && (dataRX == KEY_SPACE);
  assign w_restart    = WR_RX && (dataRX == KEY_RESTART);
  // Legality is judged against the committed direction, not the pending one
  assign w_dir_accept = w_key_is_dir && (r_state != ST_DEAD) &&
                        !is_opposite(r_dir, w_key_dir);
  // collision only matters in the cycle right after a step pulse
  assign w_dead_hit   = r_check && collision;

  // Next-state logic; restart overrides everything, including a collision
  always_comb begin
    w_state_next = r_state;
    if (w_restart) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_key_space) w_state_next = ST_RUN;
        ST_RUN: begin
          if (w_dead_hit)       w_state_next = ST_DEAD;
          else if (w_key_space) w_state_next = ST_PAUSE;
        end
        ST_PAUSE: if (w_key_space) w_state_next = ST_RUN;
        ST_DEAD:  w_state_next = ST_DEAD;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Counter runs only while staying in RUN, so a pause on the terminal
  // cycle freezes it at TICK_DIV-1 and the step fires right after resume
  assign w_tick_en  = (r_state == ST_RUN) && (w_state_next == ST_RUN);
  assign w_tick_clr = w_restart || (r_state == ST_IDLE) || (r_state == ST_DEAD);

  snake_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_tick_clr),
    .en       (w_tick_en),
    .terminal (w_tick)
  );

  // Head arithmetic in the direction about to be committed, with wrap
  always_comb begin
    w_head_x_next = r_head_x;
    w_head_y_next = r_head_y;
    case (r_pending_dir)
      DIR_UP:    w_head_y_next = (r_head_y == 5'd0)  ? Y_LAST : r_head_y - 5'd1;
      DIR_RIGHT: w_head_x_next = (r_head_x == X_LAST) ? 6'd0  : r_head_x + 6'd1;
      DIR_DOWN:  w_head_y_next = (r_head_y == Y_LAST) ? 5'd0  : r_head_y + 5'd1;
      DIR_LEFT:  w_head_x_next = (r_head_x == 6'd0)  ? X_LAST : r_head_x - 6'd1;
      default:   w_head_x_next = r_head_x;
    endcase
  end

  // Head, direction and pulse registers
  always_ff @(posedge clk) begin
    if (rst || w_restart) begin
      r_head_x      <= X_START;
      r_head_y      <= Y_START;
      r_dir         <= DIR_RIGHT;
      r_pending_dir <= DIR_RIGHT;
      r_step        <= 1'b0;
      r_check       <= 1'b0;
      r_clear       <= !rst && w_restart;
    end else begin
      r_clear <= 1'b0;
      r_step  <= w_tick;
      r_check <= r_step;
      if (w_tick) begin
        r_dir    <= r_pending_dir;
        r_head_x <= w_head_x_next;
        r_head_y <= w_head_y_next;
      end
      if (w_dir_accept) begin
        r_pending_dir <= w_key_dir;
      end
    end
  end

  assign head_x = r_head_x;
  assign head_y = r_head_y;
  assign dir    = r_dir;
  assign step   = r_step;
  assign clear  = r_clear;
  assign state  = r_state;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl with a short prescaler (TICK_DIV=4).
module tb_snake_step_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dataRX;
  logic       WR_RX;
  logic       collision;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [1:0] dir;
  logic       step;
  logic       clear;
  logic [1:0] state;

  int n_total  = 0;
  int n_passed = 0;

  snake_step_ctrl #(
    .TICK_DIV (4),
    .GRID_W   (40),
    .GRID_H   (30),
    .START_X  (20),
    .START_Y  (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dataRX    (dataRX),
    .WR_RX     (WR_RX),
    .collision (collision),
    .head_x    (head_x),
    .head_y    (head_y),
    .dir       (dir),
    .step      (step),
    .clear     (clear),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic [7:0] data;
    logic       col;
    logic [1:0] st;
    logic       stp;
    logic [5:0] x;
    logic [4:0] y;
    logic [1:0] d;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_passed++;
      $display("check %s: %0d ok", name, act);
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: inputs held across the edge, outputs sampled 1 ns after it
  task automatic tick(input logic wr, input logic [7:0] d, input logic col,
                      input logic r);
    WR_RX     = wr;
    dataRX    = d;
    collision = col;
    rst       = r;
    @(posedge clk);
    #1;
    WR_RX     = 1'b0;
    dataRX    = 8'h00;
    collision = 1'b0;
    rst       = 1'b0;
  endtask

  // Idle clocks until a step pulse is seen, bounded
  task automatic wait_step(input string name);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      if (step) break;
    end
    chk(name, int'(step), 1);
  endtask

  int exp_x;
  int exp_y;
  int steps_seen;

  initial begin
    // {wr, data, col, state, step, x, y, dir}
    vecs[0]  = '{1'b1, 8'h20, 1'b0, 2'd1, 1'b0, 6'd20, 5'd15, 2'd1};  // start
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 6'd20, 5'd15, 2'd1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 6'd20, 5'd15, 2'd1};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 6'd20, 5'd15, 2'd1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 6'd21, 5'd15, 2'd1};  // first step
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 6'd21, 5'd15, 2'd1};
    vecs[6]  = '{1'b1, 8'h61, 1'b0, 2'd1, 1'b0, 6'd21, 5'd15, 2'd1};  // 'a' opposite
    vecs[7]  = '{1'b1, 8'h77, 1'b0, 2'd1, 1'b0, 6'd21, 5'd15, 2'd1};  // 'w'
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 6'd21, 5'd14, 2'd0};  // step up
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 2'd1, 1'b0, 6'd21, 5'd14, 2'd0};  // col in step cycle
    vecs[10] = '{1'b1, 8'h57, 1'b0, 2'd1, 1'b0, 6'd21, 5'd14, 2'd0};  // 'W' ignored
    vecs[11] = '{1'b0, 8'h64, 1'b1, 2'd1, 1'b0, 6'd21, 5'd14, 2'd0};  // no WR_RX
    vecs[12] = '{1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 6'd21, 5'd13, 2'd0};

    WR_RX = 1'b0; dataRX = 8'h00; collision = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    chk("reset_state", int'(state), 0);
    chk("reset_x", int'(head_x), 20);
    chk("reset_y", int'(head_y), 15);
    chk("reset_dir", int'(dir), 1);
    chk("reset_step", int'(step), 0);
    chk("reset_clear", int'(clear), 0);

    for (int i = 0; i < 13; i++) begin
      tick(vecs[i].wr, vecs[i].data, vecs[i].col, 1'b0);
      n_total++;
      if ({state, step, head_x, head_y, dir} ==
          {vecs[i].st, vecs[i].stp, vecs[i].x, vecs[i].y, vecs[i].d}) begin
        n_passed++;
        $display("vec%0d ok: st=%0d stp=%0d x=%0d y=%0d d=%0d",
                 i, state, step, head_x, head_y, dir);
      end else begin
        $display("FAIL vec%0d: got st=%0d stp=%0d x=%0d y=%0d d=%0d clr=%0d, expected st=%0d stp=%0d x=%0d y=%0d d=%0d clr=0",
                 i, state, step, head_x, head_y, dir, clear,
                 vecs[i].st, vecs[i].stp, vecs[i].x, vecs[i].y, vecs[i].d);
      end
    end

    // Move up from row 13 through row 0 and wrap to row 29
    exp_y = 13;
    for (int k = 0; k < 14; k++) begin
      wait_step($sformatf("up_step%0d", k));
      exp_y = (exp_y == 0) ? 29 : exp_y - 1;
      chk($sformatf("up_y%0d", k), int'(head_y), exp_y);
    end
    chk("up_wrap_x", int'(head_x), 21);

    // Turn right and run off the right edge to column 0
    tick(1'b1, 8'h64, 1'b0, 1'b0);
    exp_x = 21;
    for (int k = 0; k < 19; k++) begin
      wait_step($sformatf("right_step%0d", k));
      exp_x = (exp_x == 39) ? 0 : exp_x + 1;
      chk($sformatf("right_x%0d", k), int'(head_x), exp_x);
    end
    chk("right_wrap_y", int'(head_y), 29);
    chk("right_dir", int'(dir), 1);

    // Pause exactly on the terminal count: no step, and resume steps next clk
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b1, 8'h20, 1'b0, 1'b0);
    chk("pause_state", int'(state), 2);
    chk("pause_nostep", int'(step), 0);
    chk("pause_x", int'(head_x), 0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("paused_nostep", int'(step), 0);
    tick(1'b1, 8'h20, 1'b0, 1'b0);
    chk("resume_state", int'(state), 1);
    chk("resume_nostep", int'(step), 0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("resume_step", int'(step), 1);
    chk("resume_x", int'(head_x), 1);

    // Collision in the check cycle kills the snake
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    chk("dead_state", int'(state), 3);
    steps_seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, (k == 3) ? 8'h20 : 8'h73, 1'b0, 1'b0);
      if (step) steps_seen++;
    end
    chk("dead_nosteps", steps_seen, 0);
    chk("dead_hold", int'(state), 3);
    chk("dead_x", int'(head_x), 1);

    // Restart from DEAD
    tick(1'b1, 8'h72, 1'b0, 1'b0);
    chk("restart_state", int'(state), 0);
    chk("restart_clear", int'(clear), 1);
    chk("restart_x", int'(head_x), 20);
    chk("restart_y", int'(head_y), 15);
    chk("restart_dir", int'(dir), 1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("clear_pulse_end", int'(clear), 0);

    // Restart coincident with a check-cycle collision
    tick(1'b1, 8'h20, 1'b0, 1'b0);
    wait_step("rc_step");
    chk("rc_x", int'(head_x), 21);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b1, 8'h72, 1'b1, 1'b0);
    chk("rc_state", int'(state), 0);
    chk("rc_clear", int'(clear), 1);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rc_state_hold", int'(state), 0);

    // Reset asserted in the check cycle with a collision
    tick(1'b1, 8'h20, 1'b0, 1'b0);
    wait_step("rst_step");
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b1);
    chk("rst_check_state", int'(state), 0);
    chk("rst_check_x", int'(head_x), 20);
    chk("rst_check_clear", int'(clear), 0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_check_hold", int'(state), 0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
